// File: rtl/sram_like_responder_pkg.sv
// sram_like_pkg: shared state encoding, size codes and byte-mask helper for the sram-like data interface.
package sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Lane-enable mask for a store; any size code above SZ_HALF is a full word.
    function automatic logic [3:0] size_to_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        size_to_mask = size == SZ_BYTE ? 4'b0001 << addr_lo :
                       size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// sram_like_if: sram-like data bus between an initiator (master) and a responder (slave).
interface sram_like_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok
    );
endinterface

// File: rtl/sram_like_responder_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) driving response stalls.
// Only built when SRAM_RESP_STALL_EN is defined.
`ifdef SRAM_RESP_STALL_EN
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    logic [15:0] q_q;
    logic        fb_d;

    assign fb_d = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
    assign q    = q_q;

    always_ff @(posedge clk) begin
        if (!rst) q_q <= 16'hACE1;
        else      q_q <= {q_q[14:0], fb_d};
    end
endmodule
`endif

// File: rtl/sram_like_responder.sv
// sram_like_responder: single-outstanding sram-like responder over a word memory with fixed latency.
// Define SRAM_RESP_STALL_EN to add LFSR-driven acceptance gating and 0..3 extra latency cycles.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input logic        clk,
    input logic        rst,
    sram_like_if.slave bus
);
    localparam int AW = DEPTH_LOG2 + 2;

    state_t          state_q;
    logic [4:0]      cnt_q;
    logic            wr_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            data_ok_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [0:(1<<DEPTH_LOG2)-1];

    logic [1:0]      extra_d;
    logic            gate_d;
    logic            accept_d;
    logic [4:0]      busy_n_d;
    logic [3:0]      mask_d;

`ifdef SRAM_RESP_STALL_EN
    logic [15:0] lfsr_d;
    lfsr16 u_lfsr (.clk(clk), .rst(rst), .q(lfsr_d));
    assign extra_d = lfsr_d[1:0];
    assign gate_d  = ~lfsr_d[2];
`else
    assign extra_d = 2'b00;
    assign gate_d  = 1'b1;
`endif

    assign accept_d = rst && state_q == IDLE && bus.data_req && gate_d;
    // Number of BUSY cycles between acceptance and RESP.
    assign busy_n_d = 5'(LATENCY - 1) + {3'b000, extra_d};
    assign mask_d   = size_to_mask(size_q, addr_q[1:0]);

    assign bus.data_addr_ok = accept_d;
    assign bus.data_data_ok = data_ok_q;
    assign bus.data_rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept_d) begin
                    wr_q    <= bus.data_wr;
                    size_q  <= bus.data_size;
                    addr_q  <= bus.data_addr[AW-1:0];
                    wdata_q <= bus.data_wdata;
                    if (busy_n_d == '0) begin
                        state_q   <= RESP;
                        data_ok_q <= 1'b1;
                        if (!bus.data_wr) rdata_q <= mem[bus.data_addr[AW-1:2]];
                    end else begin
                        state_q <= BUSY;
                        cnt_q   <= busy_n_d - 5'd1;
                    end
                end
                BUSY: if (cnt_q == '0) begin
                    state_q   <= RESP;
                    data_ok_q <= 1'b1;
                    if (!wr_q) rdata_q <= mem[addr_q[AW-1:2]];
                end else begin
                    cnt_q <= cnt_q - 5'd1;
                end
                default: begin
                    state_q   <= IDLE;
                    data_ok_q <= 1'b0;
                end
            endcase
        end
    end

    // Writes commit at the edge leaving RESP, so a following read sees the merged word.
    always_ff @(posedge clk) begin
        if (rst && state_q == RESP && wr_q)
            for (int b = 0; b < 4; b++)
                if (mask_d[b]) mem[addr_q[AW-1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
    end

endmodule
